flag_branch_unit: RTL and testbench
===================================

# flag_branch_unit

Resolves conditional branches against ALU status in the EX stage of the 5-stage pipeline. It holds the architectural flag register (carry, zero, compare), updated from ALU `flag`/`cmp` outputs according to the ALU control code. It evaluates branch conditions against that register (with same-cycle bypass), issues a registered PC redirect, and holds the IF/ID flush for a fixed number of cycles.

## Interface
- `ADDR_W`, 32, PC / branch target width
- `FLUSH_CYCLES`, 2, cycles `flush` is held after a taken branch (legal 1..7)
- `clk` in 1: rising-edge clock
- `rst_n` in 1: reset, asynchronous, active-low
- `alu_valid` in 1: ALU result valid this cycle
- `alu_ctrl` in 4: ALU control code of the valid op
- `alu_flag` in 2: {carry, zero} from ALU
- `alu_cmp` in 2: compare result from ALU (10 gt, 01 lt, 00 eq, 11 none)
- `br_valid` in 1: branch request
- `br_cond` in 3: condition code
- `br_target` in ADDR_W: target PC
- `br_ready` out 1: branch accepted when `br_valid & br_ready`
- `redirect_valid` out 1: one-cycle pulse, PC must load `redirect_pc`
- `redirect_pc` out ADDR_W: registered target
- `flush` out 1: squash IF/ID
- `flags_q` out 4: {carry, zero, cmp[1:0]}
- `taken_cnt` out 16: saturating count of taken branches

## Operation
- Flag update, only when `alu_valid` and FSM in IDLE:
  - ctrl 1,2,3,4,5,6,8,10,11: carry/zero ← `alu_flag`; cmp unchanged.
  - ctrl 7: cmp ← `alu_cmp`; carry/zero unchanged.
  - ctrl 0, 9, 12–15: no update.
- Conditions: 0 always; 1 zero; 2 !zero; 3 carry; 4 !carry; 5 cmp==10; 6 cmp==01; 7 cmp==00. cmp==11 fails 5/6/7.
- Bypass: the effective flags are the next-state flags. A same-cycle flag-writing ALU op counts as older than the branch.
- FSM states:
  - IDLE: `br_ready`=1.
    - Accepted and taken → FLUSH, counter ← FLUSH_CYCLES−1.
    - Accepted and not taken → stay in IDLE, no outputs change.
  - FLUSH: `br_ready`=0 and `flush`=1.
    - `alu_valid` is ignored (wrong path).
    - Counter decrements; at 0 the next state is IDLE.
- `taken_cnt` increments on every taken branch and saturates at 0xFFFF.

## Timing
- Reset values:
  - `redirect_valid`=0, `redirect_pc`=0, `flush`=0, `br_ready`=1 (IDLE).
  - `flags_q`=4'b0011 (carry 0, zero 0, cmp 11).
  - `taken_cnt`=0.
- Latency: a taken branch accepted at edge N gives `redirect_valid`=1 and `flush`=1 in cycle N+1.
- `redirect_valid` is high for exactly one cycle. `flush` stays high for FLUSH_CYCLES cycles.
- `flags_q` reflects an update one cycle after the accepting edge.
- Back-to-back: a branch presented in the cycle right after FLUSH ends is accepted normally.
- `br_valid` while `br_ready`=0 is not accepted. The requester holds it; the unit does not queue it.
- Reset mid-FLUSH: all outputs return to reset values immediately; any pending redirect is lost.
- FLUSH_CYCLES=1: a single FLUSH cycle, then IDLE.

## Structure
- Shared package `pipe_pkg`:
  - ALU control code localparams (ADD=1, SUB=2, …, CMP=7, ADDI=10, SUBI=11).
  - Condition code enum `br_cond_t`.
  - cmp encodings.
  - Reset constant for `flags_q`.
- One sub-module `br_cond_eval`: combinational decoder of (cond, carry, zero, cmp) → taken. It is reused by the decode-stage predictor.
- The FSM, flag register and counter are in the top module.

## Test plan
- Reset, then cond=1 with no ALU op → not taken. `flags_q`=0011, `redirect_valid` stays 0.
- `alu_ctrl`=2, flag=01, then cond=1 with target 0x100 → `redirect_valid` pulse with `redirect_pc`=0x100, then `flush` high 2 cycles, `br_ready` low 2 cycles.
- Same cycle: `alu_ctrl`=7 with cmp=10 and `br_cond`=5 → taken (bypass). `flags_q`=0010 next cycle.
- During FLUSH: `alu_valid`, ctrl=1, flag=10 → `flags_q` unchanged. A branch held during FLUSH is accepted in the first IDLE cycle.
- Deassert `rst_n` in the first FLUSH cycle → `flush`=0, `br_ready`=1, `flags_q`=0011 asynchronously.
- Preload `taken_cnt` near saturation (force to 0xFFFE) and issue 3 taken branches → count reads 0xFFFF and holds.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: ALU control codes, branch condition codes,
// compare encodings and the flag register reset value.
package pipe_pkg;

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_AND  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_CMP  = 4'd7;
    localparam logic [3:0] ALU_SHR  = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd9;
    localparam logic [3:0] ALU_ADDI = 4'd10;
    localparam logic [3:0] ALU_SUBI = 4'd11;

    localparam logic [1:0] CMP_EQ   = 2'b00;
    localparam logic [1:0] CMP_LT   = 2'b01;
    localparam logic [1:0] CMP_GT   = 2'b10;
    localparam logic [1:0] CMP_NONE = 2'b11;

    // {carry, zero, cmp[1:0]}
    localparam logic [3:0] FLAGS_RESET = {1'b0, 1'b0, CMP_NONE};

    typedef enum logic [2:0] {
        CondAlways   = 3'd0,
        CondZero     = 3'd1,
        CondNotZero  = 3'd2,
        CondCarry    = 3'd3,
        CondNotCarry = 3'd4,
        CondGt       = 3'd5,
        CondLt       = 3'd6,
        CondEq       = 3'd7
    } br_cond_t;

    // Ops whose {carry, zero} result is architecturally visible.
    function automatic logic writes_cz(input logic [3:0] ctrl);
        case (ctrl)
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SHL,
            ALU_SHR, ALU_ADDI, ALU_SUBI: return 1'b1;
            default:                     return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/br_cond_eval.sv
// Combinational branch condition decoder; shared with the decode-stage predictor.
module br_cond_eval
    import pipe_pkg::*;
(
    input  br_cond_t   cond,
    input  logic       carry,
    input  logic       zero,
    input  logic [1:0] cmp,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CondAlways:   taken = 1'b1;
            CondZero:     taken = zero;
            CondNotZero:  taken = ~zero;
            CondCarry:    taken = carry;
            CondNotCarry: taken = ~carry;
            CondGt:       taken = (cmp == CMP_GT);
            CondLt:       taken = (cmp == CMP_LT);
            CondEq:       taken = (cmp == CMP_EQ);
            default:      taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/flag_branch_unit.sv
// EX-stage branch resolution: architectural flag register, condition check with
// same-cycle bypass, registered PC redirect and a fixed-length IF/ID flush.
module flag_branch_unit
    import pipe_pkg::*;
#(
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    input  logic [3:0]        alu_ctrl,
    input  logic [1:0]        alu_flag,
    input  logic [1:0]        alu_cmp,
    input  logic              br_valid,
    input  logic [2:0]        br_cond,
    input  logic [ADDR_W-1:0] br_target,
    output logic              br_ready,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_pc,
    output logic              flush,
    output logic [3:0]        flags_q,
    output logic [15:0]       taken_cnt
);

    typedef enum logic [0:0] {StIdle, StFlush} state_t;

    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [3:0]        flags_d;
    logic [3:0]        flags_r;
    logic              redirect_valid_q;
    logic [ADDR_W-1:0] redirect_pc_q;
    logic [15:0]       taken_cnt_q;
    logic              cond_taken;
    logic              br_taken;

    // Next-state flags; the branch evaluates against these so a same-cycle
    // flag-writing op is treated as older than the branch.
    always_comb begin
        flags_d = flags_r;
        if (alu_valid && state_q == StIdle) begin
            if (writes_cz(alu_ctrl)) begin
                flags_d[3:2] = alu_flag;
            end else if (alu_ctrl == ALU_CMP) begin
                flags_d[1:0] = alu_cmp;
            end
        end
    end

    br_cond_eval u_cond_eval (
        .cond  (br_cond_t'(br_cond)),
        .carry (flags_d[3]),
        .zero  (flags_d[2]),
        .cmp   (flags_d[1:0]),
        .taken (cond_taken)
    );

    assign br_taken = br_valid && br_ready && cond_taken;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (br_taken) begin
                    state_d = StFlush;
                    cnt_d   = 3'(FLUSH_CYCLES - 1);
                end
            end
            StFlush: begin
                if (cnt_q == 3'd0) begin
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        br_ready = (state_q == StIdle);
        flush    = (state_q == StFlush);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_r          <= FLAGS_RESET;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            taken_cnt_q      <= 16'd0;
        end else begin
            flags_r          <= flags_d;
            redirect_valid_q <= br_taken;
            if (br_taken) begin
                redirect_pc_q <= br_target;
            end
            if (br_taken && taken_cnt_q != 16'hFFFF) begin
                taken_cnt_q <= taken_cnt_q + 16'd1;
            end
        end
    end

    assign flags_q        = flags_r;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign taken_cnt      = taken_cnt_q;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed self-checking bench for flag_branch_unit (ADDR_W=32, FLUSH_CYCLES=2).
module tb_flag_branch_unit;

    logic        clk;
    logic        rst_n;
    logic        alu_valid;
    logic [3:0]  alu_ctrl;
    logic [1:0]  alu_flag;
    logic [1:0]  alu_cmp;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic [31:0] br_target;
    logic        br_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        flush;
    logic [3:0]  flags_q;
    logic [15:0] taken_cnt;

    int checks = 0;
    int errors = 0;

    flag_branch_unit #(
        .ADDR_W       (32),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .alu_valid      (alu_valid),
        .alu_ctrl       (alu_ctrl),
        .alu_flag       (alu_flag),
        .alu_cmp        (alu_cmp),
        .br_valid       (br_valid),
        .br_cond        (br_cond),
        .br_target      (br_target),
        .br_ready       (br_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .flags_q        (flags_q),
        .taken_cnt      (taken_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic set_flags(input logic [3:0] ctrl, input logic [1:0] flg, input logic [1:0] cmp);
        @(negedge clk);
        alu_valid = 1'b1;
        alu_ctrl  = ctrl;
        alu_flag  = flg;
        alu_cmp   = cmp;
        @(negedge clk);
        alu_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        checks++; if (br_ready !== 1'b1) begin errors++; $display("FAIL reset_br_ready: got %b want 1", br_ready); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL reset_flush: got %b want 0", flush); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL reset_redirect_valid: got %b want 0", redirect_valid); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_redirect_pc: got %h want 0", redirect_pc); end
        checks++; if (flags_q !== 4'b0011) begin errors++; $display("FAIL reset_flags: got %b want 0011", flags_q); end
        checks++; if (taken_cnt !== 16'h0) begin errors++; $display("FAIL reset_taken_cnt: got %h want 0", taken_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_not_taken();
        @(negedge clk);
        br_valid = 1'b1; br_cond = 3'd1; br_target = 32'h40;
        @(negedge clk);
        br_valid = 1'b0;
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL nt_redirect: got %b want 0", redirect_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL nt_flush: got %b want 0", flush); end
        checks++; if (flags_q !== 4'b0011) begin errors++; $display("FAIL nt_flags: got %b want 0011", flags_q); end
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL nt_redirect_later: got %b want 0", redirect_valid); end
    endtask

    task automatic test_taken();
        set_flags(4'd2, 2'b01, 2'b00);
        checks++; if (flags_q !== 4'b0111) begin errors++; $display("FAIL tk_flags: got %b want 0111", flags_q); end
        br_valid = 1'b1; br_cond = 3'd1; br_target = 32'h100;
        @(negedge clk);
        br_valid = 1'b0;
        checks++; if (redirect_valid !== 1'b1) begin errors++; $display("FAIL tk_redirect: got %b want 1", redirect_valid); end
        checks++; if (redirect_pc !== 32'h100) begin errors++; $display("FAIL tk_pc: got %h want 100", redirect_pc); end
        checks++; if (flush !== 1'b1 || br_ready !== 1'b0) begin errors++; $display("FAIL tk_flush1: got flush=%b ready=%b want 1/0", flush, br_ready); end
        checks++; if (taken_cnt !== 16'd1) begin errors++; $display("FAIL tk_cnt: got %0d want 1", taken_cnt); end
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL tk_redirect_pulse: got %b want 0", redirect_valid); end
        checks++; if (flush !== 1'b1 || br_ready !== 1'b0) begin errors++; $display("FAIL tk_flush2: got flush=%b ready=%b want 1/0", flush, br_ready); end
        @(negedge clk);
        checks++; if (flush !== 1'b0 || br_ready !== 1'b1) begin errors++; $display("FAIL tk_flush_end: got flush=%b ready=%b want 0/1", flush, br_ready); end
    endtask

    task automatic test_back_to_back();
        set_flags(4'd1, 2'b00, 2'b00);
        checks++; if (flags_q !== 4'b0011) begin errors++; $display("FAIL b2b_clear: got %b want 0011", flags_q); end
        // CMP and a cmp==10 branch in the same cycle
        alu_valid = 1'b1; alu_ctrl = 4'd7; alu_cmp = 2'b10;
        br_valid = 1'b1; br_cond = 3'd5; br_target = 32'h200;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL bypass_redirect: got %b/%h want 1/200", redirect_valid, redirect_pc); end
        checks++; if (flags_q !== 4'b0010) begin errors++; $display("FAIL bypass_flags: got %b want 0010", flags_q); end
        // wrong-path ALU op and a held branch during FLUSH
        alu_ctrl = 4'd1; alu_flag = 2'b10;
        br_cond = 3'd0; br_target = 32'h300;
        @(negedge clk);
        alu_valid = 1'b0;
        checks++; if (flags_q !== 4'b0010) begin errors++; $display("FAIL flush_alu_ignored: got %b want 0010", flags_q); end
        checks++; if (redirect_valid !== 1'b0) begin errors++; $display("FAIL held_not_accepted: got %b want 0", redirect_valid); end
        @(negedge clk);
        checks++; if (br_ready !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL b2b_idle: got ready=%b flush=%b want 1/0", br_ready, flush); end
        @(negedge clk);
        br_valid = 1'b0;
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h300) begin errors++; $display("FAIL b2b_redirect: got %b/%h want 1/300", redirect_valid, redirect_pc); end
        checks++; if (taken_cnt !== 16'd3) begin errors++; $display("FAIL b2b_cnt: got %0d want 3", taken_cnt); end
        checks++; if (flags_q !== 4'b0010) begin errors++; $display("FAIL b2b_flags: got %b want 0010", flags_q); end
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_flush();
        br_valid = 1'b1; br_cond = 3'd0; br_target = 32'h400;
        @(negedge clk);
        br_valid = 1'b0;
        checks++; if (flush !== 1'b1) begin errors++; $display("FAIL rmf_flush_pre: got %b want 1", flush); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (flush !== 1'b0 || br_ready !== 1'b1) begin errors++; $display("FAIL rmf_fsm: got flush=%b ready=%b want 0/1", flush, br_ready); end
        checks++; if (flags_q !== 4'b0011) begin errors++; $display("FAIL rmf_flags: got %b want 0011", flags_q); end
        checks++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL rmf_redirect: got %b/%h want 0/0", redirect_valid, redirect_pc); end
        checks++; if (taken_cnt !== 16'd0) begin errors++; $display("FAIL rmf_cnt: got %0d want 0", taken_cnt); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (redirect_valid !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL rmf_lost: got redirect=%b flush=%b want 0/0", redirect_valid, flush); end
    endtask

    // Expected-taken mask per condition code for one flag setting.
    task automatic run_conds(input string tag, input logic [7:0] mask);
        for (int c = 0; c < 8; c++) begin
            br_valid = 1'b1; br_cond = 3'(c); br_target = 32'(c * 16);
            @(negedge clk);
            br_valid = 1'b0;
            checks++;
            if (redirect_valid !== mask[c]) begin
                errors++;
                $display("FAIL cond_%s_%0d: got %b want %b", tag, c, redirect_valid, mask[c]);
            end
            if (mask[c]) begin
                @(negedge clk);
                @(negedge clk);
            end
        end
    endtask

    task automatic test_conditions();
        run_conds("reset", 8'h15);
        set_flags(4'd1, 2'b10, 2'b00);
        set_flags(4'd7, 2'b00, 2'b01);
        checks++; if (flags_q !== 4'b1001) begin errors++; $display("FAIL cond_flags_a: got %b want 1001", flags_q); end
        run_conds("a", 8'h4D);
        set_flags(4'd11, 2'b01, 2'b00);
        set_flags(4'd7, 2'b00, 2'b00);
        checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL cond_flags_b: got %b want 0100", flags_q); end
        run_conds("b", 8'h93);
        set_flags(4'd9, 2'b10, 2'b11);
        checks++; if (flags_q !== 4'b0100) begin errors++; $display("FAIL cond_noupdate: got %b want 0100", flags_q); end
    endtask

    task automatic test_saturation();
        @(negedge clk);
        force dut.taken_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.taken_cnt_q;
        @(negedge clk);
        checks++; if (taken_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_preload: got %h want fffe", taken_cnt); end
        for (int i = 0; i < 3; i++) begin
            br_valid = 1'b1; br_cond = 3'd0; br_target = 32'h500;
            @(negedge clk);
            br_valid = 1'b0;
            checks++; if (taken_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_%0d: got %h want ffff", i, taken_cnt); end
            @(negedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        alu_valid = 1'b0; alu_ctrl = 4'd0; alu_flag = 2'b00; alu_cmp = 2'b11;
        br_valid = 1'b0; br_cond = 3'd0; br_target = 32'h0;
        test_reset();
        test_not_taken();
        test_taken();
        test_back_to_back();
        test_reset_mid_flush();
        test_conditions();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
